// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
// Holds the FSM state encoding used by serial_adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_addr.sv
// 1-bit full adder cell.
// Ports:
//   a, b  - addend bits
//   cin   - carry in
//   sum   - a ^ b ^ cin
//   cout  - carry out
module full_addr (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built around one full_addr cell and a carry
// flip-flop. Operands are loaded on an accepted start and added LSB first,
// one bit per clock. The result is published with a one-cycle done pulse.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only while busy=0
//   a, b   - operands, captured on accepted start
//   cin    - carry-in, captured on accepted start
//   busy   - high while shifting
//   done   - one-cycle pulse when sum/cout update
//   sum    - last completed sum, held between operations
//   cout   - last completed carry-out, held between operations
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_SHIFT | adding one bit per clock, WIDTH clocks
// ST_DONE  | result just published; start here is accepted back-to-back
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic [WIDTH-1:0] s_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_sum, fa_cout;
  logic             last_bit;
  logic             accept;

  full_addr u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
  assign s_next   = {fa_sum, s_sh[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign accept   = start && (state_q != ST_SHIFT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = start ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: state_d = last_bit ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_SHIFT: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: shift registers, carry, bit counter and held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state_q == ST_SHIFT) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= s_next;
      carry <= fa_cout;
      cnt   <= cnt + CNT_W'(1);
      // sum/cout only move on the final bit so they hold the old result
      // throughout the shift.
      if (last_bit) begin
        sum  <= s_next;
        cout <= fa_cout;
      end
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      s_sh  <= '0;
      cnt   <= '0;
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the existing 1-bit `full_addr` cell.
- Loads two WIDTH-bit operands and a carry-in on a start pulse.
- Adds LSB-first, one bit per clock, through a single `full_addr` instance and a carry flip-flop.
- Presents the WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Sits directly downstream of the full-adder cell as its first sequential consumer; trades area for latency.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse when the result updates.
- sum  output  WIDTH  last completed sum; held between operations.
- cout  output  1  last completed carry-out; held.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low. Reset asserted forces state=IDLE and clears all registers: busy=0, done=0, sum=0, cout=0, internal shift regs, carry FF and counter.
- States:
  - IDLE: busy=0, done=0.
  - SHIFT: busy=1.
  - DONE: busy=0, done=1.
- IDLE, start=1 at edge E0:
  - a_sh<=a, b_sh<=b, carry<=cin, s_sh<=0, cnt<=0, go to SHIFT.
  - start=0 stays IDLE.
- SHIFT, every edge:
  - `full_addr` inputs are a_sh[0], b_sh[0], carry.
  - s_sh<={fa_sum, s_sh[WIDTH-1:1]}; a_sh and b_sh shift right with 0 fill; carry<=fa_cout; cnt<=cnt+1.
- Completion: on the shift edge where cnt==WIDTH-1 (edge E0+WIDTH):
  - sum<={fa_sum, s_sh[WIDTH-1:1]}, cout<=fa_cout, go to DONE.
- DONE lasts exactly one cycle:
  - start=1 there is accepted exactly as in IDLE (back-to-back, new load, go SHIFT).
  - Otherwise go to IDLE.
- Latency: done high in the cycle after edge E0+WIDTH. Throughput: one add per WIDTH+1 cycles back-to-back.
- start while busy=1 is ignored; no queuing, no error flag.
- a, b, cin are don't-care except at the accepting edge.
- sum/cout change only at the completion edge. They keep the previous result during SHIFT.
- Arithmetic: {cout,sum} == a+b+cin, modulo 2^(WIDTH+1); no overflow flag.
- cnt width = $clog2(WIDTH); saturation is not needed since SHIFT exits at WIDTH-1.
- Reset mid-SHIFT abandons the operation: no done pulse, sum/cout cleared to 0.

Decomposition:
- Shared package `serial_adder_pkg`: state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
- One sub-module: the existing `full_addr` (ports a, b, cin, sum, cout), instantiated once, unmodified.
- Everything else (FSM, shift regs, counter) is flat in serial_adder.

Test Plan:
- Bench uses WIDTH=8 throughout.
1. Reset, then start with a=8'h00, b=8'h00, cin=0 -> busy high 8 cycles; done pulse at cycle 9; sum=8'h00, cout=0.
2. a=8'h3C, b=8'h42, cin=0 -> sum=8'h7E, cout=0. During SHIFT, sum/cout hold the previous result (8'h00/0).
3. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=1 started in the DONE cycle -> accepted; after 8 more busy cycles, sum=8'h00, cout=1.
4. Start a=8'h12, b=8'h34; pulse start with a=8'hFF at busy cycle 3 -> ignored; result sum=8'h46, cout=0; exactly one done pulse.
5. Start a=8'hF0, b=8'h0F; assert rst_n=0 asynchronously mid-cycle at busy cycle 4 -> outputs 0 immediately, no done pulse. After release, idle until next start.
6. Random self-check: 200 starts with random a, b, cin at random idle gaps -> {cout,sum}==a+b+cin every done; done width always 1 cycle.
